// File: rtl/sha_pkg.sv
// Shared SHA-256 constants and the message feeder state encoding.
// Also used by sha_core.
package sha_pkg;

    localparam int unsigned SHA_BLOCK_W  = 512;
    localparam int unsigned SHA_WORD_W   = 32;
    localparam int unsigned SHA_LEN_W    = 64;
    localparam int unsigned SHA_WORDS    = 16;
    localparam logic [7:0]  SHA_PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StPad,
        StLen,
        StIssue,
        StWait
    } feeder_state_e;

    // Final partial word: keep the valid bytes, put the pad byte right after them,
    // and zero everything beyond it.
    function automatic logic [SHA_WORD_W-1:0] pad_last_word(input logic [SHA_WORD_W-1:0] data,
                                                            input logic [2:0] nbytes);
        logic [SHA_WORD_W-1:0] w;
        case (nbytes)
            3'd0:    w = {SHA_PAD_BYTE, 24'h000000};
            3'd1:    w = {data[31:24], SHA_PAD_BYTE, 16'h0000};
            3'd2:    w = {data[31:16], SHA_PAD_BYTE, 8'h00};
            3'd3:    w = {data[31:8], SHA_PAD_BYTE};
            default: w = data;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sha_block_buf.sv
// 16x32 block register file: indexed word write, synchronous clear,
// flat big-endian read-out (word 0 in the top bits).
module sha_block_buf
    import sha_pkg::*;
#(
    parameter int unsigned WORDS = SHA_WORDS
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          clear,
    input  logic                          we,
    input  logic [$clog2(WORDS)-1:0]      widx,
    input  logic [SHA_WORD_W-1:0]         wdata,
    output logic [WORDS*SHA_WORD_W-1:0]   data
);

    logic [SHA_WORD_W-1:0] mem_q [WORDS];

    // A write in the same cycle as a clear wins for its own word.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (clear) begin
                for (int i = 0; i < WORDS; i++) begin
                    mem_q[i] <= '0;
                end
            end
            if (we) begin
                mem_q[widx] <= wdata;
            end
        end
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < WORDS; i++) begin
            data[(WORDS-1-i)*SHA_WORD_W +: SHA_WORD_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/sha_msg_feeder.sv
// Streams a byte message into SHA-256 blocks with padding and length appended,
// handing each block to sha_core and waiting for it to finish.
module sha_msg_feeder
    import sha_pkg::*;
#(
    parameter int unsigned LEN_W = 64,
    parameter int unsigned WORDS = 16
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [SHA_WORD_W-1:0]  s_data,
    input  logic                   s_last,
    input  logic [2:0]             s_nbytes,
    output logic [SHA_BLOCK_W-1:0] blk_data,
    output logic                   blk_start,
    output logic                   blk_first,
    input  logic                   core_valid,
    output logic                   msg_done,
    output logic                   busy
);

    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(WORDS - 1);
    localparam logic [IDX_W-1:0] LEN_HI_IDX = IDX_W'(WORDS - 2);
    localparam logic [IDX_W-1:0] PAD_END    = IDX_W'(WORDS - 3);

    feeder_state_e    state_q;
    logic [IDX_W-1:0] idx_q;
    logic [LEN_W-1:0] len_q;
    logic             first_q;
    logic             last_q;   // message fully received; remaining blocks are padding/length
    logic             extra_q;  // padding spilled over, one more block to build
    logic             pad80_q;  // next padded word starts with the pad byte
    logic             ready_q;
    logic             busy_q;
    logic             start_q;
    logic             bfirst_q;
    logic             done_q;

    logic                  beat;
    logic [LEN_W-1:0]      len_base;
    logic [LEN_W:0]        len_sum;
    logic [LEN_W-1:0]      len_next;
    logic [SHA_LEN_W-1:0]  len_field;
    logic                  buf_clear;
    logic                  buf_we;
    logic [SHA_WORD_W-1:0] buf_wdata;

    assign beat = s_valid && ready_q;

    // Saturating bit count; a new message restarts from zero.
    always_comb begin
        len_base  = (state_q == StIdle) ? '0 : len_q;
        len_sum   = {1'b0, len_base} + (LEN_W+1)'({s_nbytes, 3'b000});
        len_next  = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        len_field = SHA_LEN_W'(len_q);
    end

    always_comb begin
        buf_clear = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = '0;
        case (state_q)
            StIdle, StFill: begin
                if (beat) begin
                    buf_we    = 1'b1;
                    buf_clear = (state_q == StIdle);
                    buf_wdata = s_last ? pad_last_word(s_data, s_nbytes) : s_data;
                end
            end
            StPad: begin
                buf_we    = 1'b1;
                buf_wdata = pad80_q ? {SHA_PAD_BYTE, 24'h000000} : '0;
            end
            StLen: begin
                buf_we    = 1'b1;
                buf_wdata = (idx_q == LEN_HI_IDX) ? len_field[SHA_LEN_W-1 -: SHA_WORD_W]
                                                  : len_field[SHA_WORD_W-1:0];
            end
            default: ;
        endcase
    end

    sha_block_buf #(
        .WORDS (WORDS)
    ) u_buf (
        .clk   (clk),
        .clr   (clr),
        .clear (buf_clear),
        .we    (buf_we),
        .widx  (idx_q),
        .wdata (buf_wdata),
        .data  (blk_data)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            len_q    <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            extra_q  <= 1'b0;
            pad80_q  <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            bfirst_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            start_q  <= 1'b0;
            bfirst_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                StIdle, StFill: begin
                    ready_q <= 1'b1;
                    if (beat) begin
                        len_q <= len_next;
                        if (state_q == StIdle) begin
                            busy_q  <= 1'b1;
                            first_q <= 1'b1;
                        end
                        if (s_last) begin
                            last_q  <= 1'b1;
                            ready_q <= 1'b0;
                            pad80_q <= (s_nbytes == 3'd4);
                            if (idx_q == LAST_IDX) begin
                                state_q <= StIssue;
                                extra_q <= 1'b1;
                            end else if (idx_q == PAD_END && s_nbytes != 3'd4) begin
                                state_q <= StLen;
                                idx_q   <= idx_q + 1'b1;
                            end else begin
                                state_q <= StPad;
                                idx_q   <= idx_q + 1'b1;
                            end
                        end else if (idx_q == LAST_IDX) begin
                            state_q <= StIssue;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= StFill;
                            idx_q   <= idx_q + 1'b1;
                        end
                    end
                end
                StPad: begin
                    pad80_q <= 1'b0;
                    if (idx_q == PAD_END) begin
                        state_q <= StLen;
                        idx_q   <= idx_q + 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= StIssue;
                        extra_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StLen: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= StIssue;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StIssue: begin
                    start_q  <= 1'b1;
                    bfirst_q <= first_q;
                    first_q  <= 1'b0;
                    state_q  <= StWait;
                end
                StWait: begin
                    if (core_valid) begin
                        idx_q <= '0;
                        if (extra_q) begin
                            extra_q <= 1'b0;
                            state_q <= StPad;
                        end else if (last_q) begin
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            ready_q <= 1'b1;
                            state_q <= StFill;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign blk_start = start_q;
    assign blk_first = bfirst_q;
    assign msg_done  = done_q;
    assign busy      = busy_q;

endmodule
